// File: rtl/adder_pkg.sv
// Shared types and constants for the registered ripple-carry adder.
package adder_pkg;

    // Default operand width and the widest operand the adder is built for.
    localparam int ADDER_WIDTH = 1;
    localparam int ADDER_MAX_W = 64;

    // Result bundle as it sits in the register stage. The sum field is sized
    // for the widest build; narrower builds use the low bits only.
    typedef struct packed {
        logic                   cout;
        logic                   ovf;
        logic [ADDER_MAX_W-1:0] sum;
    } adder_res_t;

    // Signed overflow: the carry into the sign bit disagrees with the carry out.
    function automatic logic ovf_of(input logic c_into_msb, input logic c_out);
        return c_into_msb ^ c_out;
    endfunction

endpackage

// File: rtl/adder_cell.sv
// One full-adder bit built from 2:1 selects on the propagate term.
module adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate: when the operand bits differ the incoming carry passes through.
    assign p  = a ^ b;

    // Sum inverts the carry on propagate, otherwise passes it.
    assign s  = p ? ~ci : ci;

    // With a==b the carry out is simply a (generate for 1, kill for 0).
    assign co = p ? ci : a;

endmodule

// File: rtl/adder.sv
// Ripple-carry adder with a combinational result and an enable-gated
// registered copy of it. VALID_Q marks the cycle after each capture.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             EN,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic [WIDTH-1:0] SUM_Q,
    output logic             COUT_Q,
    output logic             OVF_Q,
    output logic             VALID_Q
);

    // Single register stage between the combinational result and *_Q.
    localparam int STAGES = 1;

    // Carry chain: c[0] is the carry-in, c[WIDTH] the carry-out.
    logic [WIDTH:0] c;

    assign c[0] = CIN;

    // One mux-based full-adder per operand bit, chained LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        adder_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (SUM[i]),
            .co (c[i+1])
        );
    end

    assign COUT = c[WIDTH];

    // c[WIDTH-1] is the carry into the sign bit; for WIDTH=1 that is CIN.
    assign OVF  = ovf_of(c[WIDTH-1], c[WIDTH]);

    // Pack the combinational result; unused high sum bits stay zero.
    adder_res_t res_d;
    adder_res_t res_q;

    always_comb begin
        res_d                = '0;
        res_d.cout           = COUT;
        res_d.ovf            = OVF;
        res_d.sum[WIDTH-1:0] = SUM;
    end

    // Result register: async clear, load on enable, otherwise hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            res_q <= '0;
        else if (EN)
            res_q <= res_d;
    end

    // Valid shift register: the enable enters at stage 0 and emerges as VALID_Q.
    logic [STAGES:1] vld_q;
    logic [STAGES:0] vld_pipe;

    assign vld_pipe = {vld_q, EN};

    // Valid bits advance every cycle, so a dropped enable clears VALID_Q.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            vld_q <= '0;
        else
            vld_q <= vld_pipe[STAGES-1:0];
    end

    assign SUM_Q   = res_q.sum[WIDTH-1:0];
    assign COUT_Q  = res_q.cout;
    assign OVF_Q   = res_q.ovf;
    assign VALID_Q = vld_pipe[STAGES];

    // High sum bits of the register are constant zero in narrow builds.
    logic unused_hi;
    assign unused_hi = ^res_q.sum;

endmodule

// File: tb/tb_adder.sv
// Directed and randomised checks of adder at WIDTH 1, 8 and 16.
module tb_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    // WIDTH=1 instance
    logic a1 = 0, b1 = 0, c1 = 0, en1 = 0;
    logic s1, co1, ov1, sq1, coq1, ovq1, vq1;
    // WIDTH=8 instance
    logic [7:0] a8 = 0, b8 = 0;
    logic c8 = 0, en8 = 0;
    logic [7:0] s8, sq8;
    logic co8, ov8, coq8, ovq8, vq8;
    // WIDTH=16 instance
    logic [15:0] a16 = 0, b16 = 0;
    logic c16 = 0, en16 = 0;
    logic [15:0] s16, sq16;
    logic co16, ov16, coq16, ovq16, vq16;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    adder #(.WIDTH(1)) u_w1 (
        .CLK(CLK), .RST(RST), .A(a1), .B(b1), .CIN(c1), .EN(en1),
        .SUM(s1), .COUT(co1), .OVF(ov1),
        .SUM_Q(sq1), .COUT_Q(coq1), .OVF_Q(ovq1), .VALID_Q(vq1)
    );

    adder #(.WIDTH(8)) u_w8 (
        .CLK(CLK), .RST(RST), .A(a8), .B(b8), .CIN(c8), .EN(en8),
        .SUM(s8), .COUT(co8), .OVF(ov8),
        .SUM_Q(sq8), .COUT_Q(coq8), .OVF_Q(ovq8), .VALID_Q(vq8)
    );

    adder #(.WIDTH(16)) u_w16 (
        .CLK(CLK), .RST(RST), .A(a16), .B(b16), .CIN(c16), .EN(en16),
        .SUM(s16), .COUT(co16), .OVF(ov16),
        .SUM_Q(sq16), .COUT_Q(coq16), .OVF_Q(ovq16), .VALID_Q(vq16)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    vec_t tab1[8];
    vec_t tab8[8];

    initial begin
        logic [16:0] full;
        logic [15:0] q_sum;
        logic        q_cout, q_ovf, q_vld, exp_ovf;

        // {a, b, cin, sum, cout, ovf} -- WIDTH=1 uses bit 0 only
        tab1[0] = '{8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0};
        tab1[1] = '{8'h0, 8'h0, 1'b1, 8'h1, 1'b0, 1'b1};
        tab1[2] = '{8'h0, 8'h1, 1'b0, 8'h1, 1'b0, 1'b0};
        tab1[3] = '{8'h0, 8'h1, 1'b1, 8'h0, 1'b1, 1'b0};
        tab1[4] = '{8'h1, 8'h0, 1'b0, 8'h1, 1'b0, 1'b0};
        tab1[5] = '{8'h1, 8'h0, 1'b1, 8'h0, 1'b1, 1'b0};
        tab1[6] = '{8'h1, 8'h1, 1'b0, 8'h0, 1'b1, 1'b1};
        tab1[7] = '{8'h1, 8'h1, 1'b1, 8'h1, 1'b1, 1'b0};

        tab8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tab8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tab8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tab8[3] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tab8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tab8[5] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0};
        tab8[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        tab8[7] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};

        // reset state
        #1;
        chk("rst_sum_q", 64'(sq8), 64'h0);
        chk("rst_cout_q", 64'(coq8), 64'h0);
        chk("rst_ovf_q", 64'(ovq8), 64'h0);
        chk("rst_valid_q", 64'(vq8), 64'h0);
        chk("rst_valid_q_w1", 64'(vq1), 64'h0);
        @(negedge CLK);
        RST = 1'b0;

        // WIDTH=1 exhaustive, each held 10 time units
        for (int i = 0; i < 8; i++) begin
            a1 = tab1[i].a[0];
            b1 = tab1[i].b[0];
            c1 = tab1[i].cin;
            #5;
            chk($sformatf("w1_sum[%0d]", i), 64'(s1), 64'(tab1[i].sum[0]));
            chk($sformatf("w1_cout[%0d]", i), 64'(co1), 64'(tab1[i].cout));
            chk($sformatf("w1_ovf[%0d]", i), 64'(ov1), 64'(tab1[i].ovf));
            #5;
        end

        // WIDTH=8 combinational vectors
        for (int i = 0; i < 8; i++) begin
            a8 = tab8[i].a;
            b8 = tab8[i].b;
            c8 = tab8[i].cin;
            #1;
            chk($sformatf("w8_sum[%0d]", i), 64'(s8), 64'(tab8[i].sum));
            chk($sformatf("w8_cout[%0d]", i), 64'(co8), 64'(tab8[i].cout));
            chk($sformatf("w8_ovf[%0d]", i), 64'(ov8), 64'(tab8[i].ovf));
        end

        // capture then hold
        @(negedge CLK);
        a8 = 8'h3C; b8 = 8'h0F; c8 = 1'b1; en8 = 1'b1;
        @(posedge CLK); #1;
        chk("cap_sum_q", 64'(sq8), 64'h4C);
        chk("cap_cout_q", 64'(coq8), 64'h0);
        chk("cap_ovf_q", 64'(ovq8), 64'h0);
        chk("cap_valid_q", 64'(vq8), 64'h1);
        @(negedge CLK);
        en8 = 1'b0; a8 = 8'h01;
        @(posedge CLK); #1;
        chk("hold_sum_q", 64'(sq8), 64'h4C);
        chk("hold_valid_q", 64'(vq8), 64'h0);

        // async reset between edges; combinational path keeps tracking
        #2;
        RST = 1'b1;
        #1;
        chk("arst_sum_q", 64'(sq8), 64'h0);
        chk("arst_cout_q", 64'(coq8), 64'h0);
        chk("arst_ovf_q", 64'(ovq8), 64'h0);
        chk("arst_valid_q", 64'(vq8), 64'h0);
        chk("arst_sum_live", 64'(s8), 64'h11);
        a8 = 8'h10;
        #1;
        chk("arst_sum_track", 64'(s8), 64'h20);

        // reset wins over enable on the same edge
        en8 = 1'b1;
        @(posedge CLK); #1;
        chk("rst_win_sum_q", 64'(sq8), 64'h0);
        chk("rst_win_valid_q", 64'(vq8), 64'h0);

        // after release, no capture until EN=1
        @(negedge CLK);
        RST = 1'b0; en8 = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_idle_sum_q", 64'(sq8), 64'h0);
        chk("post_rst_idle_valid", 64'(vq8), 64'h0);
        @(negedge CLK);
        en8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
        @(posedge CLK); #1;
        chk("first_cap_sum_q", 64'(sq8), 64'h80);
        chk("first_cap_cout_q", 64'(coq8), 64'h0);
        chk("first_cap_ovf_q", 64'(ovq8), 64'h1);
        chk("first_cap_valid", 64'(vq8), 64'h1);
        // back-to-back capture keeps VALID_Q high
        @(negedge CLK);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        @(posedge CLK); #1;
        chk("b2b_sum_q", 64'(sq8), 64'hFF);
        chk("b2b_cout_q", 64'(coq8), 64'h1);
        chk("b2b_ovf_q", 64'(ovq8), 64'h0);
        chk("b2b_valid", 64'(vq8), 64'h1);
        @(negedge CLK);
        en8 = 1'b0;

        // randomised WIDTH=16 against an arithmetic reference
        q_sum = 16'h0; q_cout = 1'b0; q_ovf = 1'b0; q_vld = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge CLK);
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            c16  = 1'($urandom_range(0, 1));
            en16 = ($urandom_range(0, 3) != 0);
            full = {1'b0, a16} + {1'b0, b16} + {16'h0, c16};
            exp_ovf = (a16[15] == b16[15]) && (full[15] != a16[15]);
            #1;
            chk("r16_sum", 64'(s16), 64'(full[15:0]));
            chk("r16_cout", 64'(co16), 64'(full[16]));
            chk("r16_ovf", 64'(ov16), 64'(exp_ovf));
            if (en16) begin
                q_sum = full[15:0]; q_cout = full[16]; q_ovf = exp_ovf;
            end
            q_vld = en16;
            @(posedge CLK); #1;
            chk("r16_sum_q", 64'(sq16), 64'(q_sum));
            chk("r16_cout_q", 64'(coq16), 64'(q_cout));
            chk("r16_ovf_q", 64'(ovq16), 64'(q_ovf));
            chk("r16_valid_q", 64'(vq16), 64'(q_vld));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 1, operand width in bits (legal range 1..64).
REQ-002 CLK  input  1  clock; all registers update on the rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-005 B  input  WIDTH  operand B, unsigned or two's complement.
REQ-006 CIN  input  1  carry-in.
REQ-007 EN  input  1  capture enable for the registered result stage.
REQ-008 SUM  output  WIDTH  combinational sum, low WIDTH bits of A+B+CIN.
REQ-009 COUT  output  1  combinational carry-out of A+B+CIN.
REQ-010 OVF  output  1  combinational signed overflow: carry into MSB XOR COUT.
REQ-011 SUM_Q  output  WIDTH  registered SUM.
REQ-012 COUT_Q  output  1  registered COUT.
REQ-013 OVF_Q  output  1  registered OVF.
REQ-014 VALID_Q  output  1  high for the cycle after each capture.

Function
REQ-015 {COUT,SUM} SHALL equal A+B+CIN computed at WIDTH+1 bits; no truncation except the stated split.
REQ-016 SUM, COUT and OVF SHALL be purely combinational, with zero-cycle latency from A, B and CIN, and SHALL be independent of CLK, RST and EN.
REQ-017 The combinational path SHALL be a ripple chain of WIDTH full-adder cells; cell i uses carry c[i], where c[0]=CIN and c[WIDTH]=COUT.
REQ-018 Each cell SHALL form P=A[i]^B[i], SUM[i]=P ? ~c[i] : c[i], and c[i+1]=P ? c[i] : A[i], both as 2:1 selects.
REQ-019 For WIDTH=1, OVF SHALL equal CIN XOR COUT.
REQ-020 On a rising CLK with EN=1, SUM_Q, COUT_Q and OVF_Q SHALL load SUM, COUT and OVF, and VALID_Q SHALL go to 1 (one-cycle latency).
REQ-021 On a rising CLK with EN=0, SUM_Q, COUT_Q and OVF_Q SHALL hold, and VALID_Q SHALL go to 0.
REQ-022 With EN held at 1 on consecutive cycles, the stage SHALL capture on every cycle and VALID_Q SHALL stay at 1.
REQ-023 Boundary: the all-ones + all-ones + CIN=1 case SHALL give SUM=all-ones and COUT=1; the all-ones + 0 + CIN=1 case SHALL wrap to SUM=0 and COUT=1.
REQ-024 X or Z on an input SHALL NOT be masked; X on an input propagates to the outputs.

Reset
REQ-025 RST=1 SHALL immediately force SUM_Q=0, COUT_Q=0, OVF_Q=0 and VALID_Q=0, regardless of CLK.
REQ-026 RST SHALL NOT affect SUM, COUT or OVF.
REQ-027 RST asserted mid-operation SHALL win over EN=1 on the same edge.
REQ-028 After RST deasserts, the first capture occurs on the first rising CLK with EN=1.

Structure
REQ-029 A shared package SHALL hold the default WIDTH constant and a result struct {cout, ovf, sum}.
REQ-030 One sub-module, adder_cell, SHALL implement the mux-based full-adder cell of REQ-018; adder SHALL instantiate WIDTH of these cells via a generate loop.
REQ-031 The register stage SHALL reside in adder; there SHALL be no latches and no other sequential logic.

Verification
REQ-032 WIDTH=1, exhaustively drive the 8 combinations of A, B and CIN and hold each for 10 time units -> {COUT,SUM} = 00, 01, 01, 10, 01, 10, 10, 11 respectively.
REQ-033 WIDTH=8: A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1, OVF=0; A=0x7F, B=0x01, CIN=0 -> SUM=0x80, COUT=0, OVF=1.
REQ-034 WIDTH=8: A=0x3C, B=0x0F, CIN=1, EN=1, one rising edge -> SUM_Q=0x4C, COUT_Q=0, VALID_Q=1; next edge with EN=0 -> SUM_Q holds 0x4C, VALID_Q=0.
REQ-035 Assert RST between clock edges while SUM_Q=0x4C -> SUM_Q, COUT_Q, OVF_Q and VALID_Q all read 0 before the next edge, while SUM still tracks the inputs.
REQ-036 Randomised WIDTH=16, 10k vectors -> SUM, COUT and OVF match a reference model of A+B+CIN; SUM_Q matches the model with one-cycle delay whenever EN=1.
